// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter shared definitions: FSM state encoding, reset level,
// fetch byte-select and watchdog counter width.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_BUSY  = 2'd1,
    ST_MEM_BUSY = 2'd2
  } state_e;

  localparam logic       RST_ACTIVE = 1'b0;
  localparam logic [3:0] SEL_WORD   = 4'hF;
  localparam int         WDOG_W     = 8;

endpackage

// File: rtl/wb_arbiter_watchdog.sv
// wb_watchdog: counts clocks while run is high, cleared by clr.
// Ports: clk, rst (async active-low), run, clr in; expired out.
module wb_watchdog
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_q;
  logic [WDOG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (run)
      cnt_d = cnt_q + WDOG_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires on the last allowed busy clock, so the cycle ends after LIMIT clocks.
  assign expired = run && (cnt_q == WDOG_W'(LIMIT - 1));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares one Wishbone master between fetch and data ports.
// Ports: clk, rst(async low), flush, if_*, mem_*, wb_*, stallreq_*, bus_err.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        stallreq_if,
  output logic        stallreq_mem,
  output logic        bus_err
);

  state_e      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        bus_err_q, bus_err_d;
  logic        discard_q, discard_d;

  logic        busy;
  logic        expired;
  logic        grant_mem;
  logic        grant_if;
  logic        bus_fail;
  logic        bus_end;

  assign busy = (state_q != ST_IDLE);

  // A port whose ack is high this cycle still shows last request.
  assign grant_mem = mem_req && !mem_ack_q;
  assign grant_if  = if_req && !if_ack_q;

  assign bus_fail = wb_err_i || (expired && !wb_ack_i);
  assign bus_end  = wb_ack_i || bus_fail;

  wb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .run    (busy),
    .clr    (!busy),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    discard_d   = discard_q;
    unique case (state_q)
      ST_IDLE: begin
        discard_d = 1'b0;
        if (grant_mem) begin
          state_d = ST_MEM_BUSY;
          cyc_d   = 1'b1;
          we_d    = mem_we;
          sel_d   = mem_sel;
          adr_d   = mem_addr;
          dat_d   = mem_wdata;
        end else if (grant_if) begin
          state_d   = ST_IF_BUSY;
          cyc_d     = 1'b1;
          we_d      = 1'b0;
          sel_d     = SEL_WORD;
          adr_d     = if_addr;
          dat_d     = '0;
          discard_d = flush;
        end
      end
      ST_IF_BUSY: begin
        if (flush)
          discard_d = 1'b1;
        if (bus_end) begin
          state_d   = ST_IDLE;
          cyc_d     = 1'b0;
          discard_d = 1'b0;
          bus_err_d = bus_fail;
          // A flushed fetch still finishes on the bus but is invisible.
          if (!(discard_q || flush)) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_fail ? '0 : wb_dat_i;
          end
        end
      end
      ST_MEM_BUSY: begin
        if (bus_end) begin
          state_d     = ST_IDLE;
          cyc_d       = 1'b0;
          bus_err_d   = bus_fail;
          mem_ack_d   = 1'b1;
          mem_rdata_d = (bus_fail || we_q) ? '0 : wb_dat_i;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
      discard_q   <= discard_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign bus_err   = bus_err_q;

  assign stallreq_if  = if_req && !if_ack_q;
  assign stallreq_mem = mem_req && !mem_ack_q;

endmodule
